screen_state_ctrl: RTL and testbench
====================================

Name: screen_state_ctrl

Overview:
- Game-level screen sequencer that configures the VGA object priority mux.
- Runs the title / play / pause / win / lose flow from player events and frame ticks.
- Drives a per-layer enable mask that gates each drawing request into the mux, plus win/lose overlay enables.
- State changes only at frame boundaries, so no screen tears mid-frame.

Parameters:
- NUM_LAYERS, 8, width of the layer mask. Bit order: [0]score [1]lava [2]platform [3]rope [4]target [5]kong [6]lose [7]win.
- BLINK_FRAMES, 30, frames per blink half-period.
- WIN_HOLD_FRAMES, 180, frames the win screen is held before returning to title.
- LOSE_HOLD_FRAMES, 180, frames the lose screen is held before returning to title.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- startKey  in  1  pulse or level, start request.
- pauseKey  in  1  pulse, pause toggle request.
- playerWon  in  1  pulse, target reached.
- playerDied  in  1  pulse, player hit lava or lost.
- layerEnable  out  NUM_LAYERS  per-layer gate, ANDed externally with each drawing request.
- winShow  out  1  win overlay visible.
- loseShow  out  1  lose overlay visible.
- gameActive  out  1  game logic may advance.
- restartPulse  out  1  one-cycle pulse that reinitialises game objects.
- stateOut  out  3  encoded state, for debug.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, resetN.
- Reset values (async, any time, including mid-hold): state TITLE (0), layerEnable 8'h0F, winShow 0, loseShow 0, gameActive 0, restartPulse 0, all event latches 0, frame counter 0, blink phase 1.
- Event latches: startKey, pauseKey, playerWon and playerDied are each OR-sticky.
  - Set the cycle after they are asserted.
  - An event coincident with startOfFrame counts for that frame: the effective event is input OR latch.
  - All latches clear on every startOfFrame cycle, whether consumed or not.
- Transitions are evaluated only on cycles with startOfFrame=1. Outputs are registered and take new values on the same edge the state changes.
- TITLE:
  - Mask 8'h0F, gameActive 0.
  - start -> PLAY, restartPulse=1 for exactly one cycle.
- PLAY:
  - Mask 8'h3F, gameActive 1.
  - Priority within one frame: won > died > pause. won -> WIN; died -> LOSE; pause -> PAUSE.
- PAUSE:
  - gameActive 0.
  - Mask 8'h3F, except bit[5] (kong) follows the blink phase.
  - pause -> PLAY. won, died and start are discarded.
- WIN:
  - winShow = blink phase; mask 8'h3F, with bit7 = blink phase.
  - The counter increments each frame. When count == WIN_HOLD_FRAMES-1 at startOfFrame -> TITLE. All keys ignored.
- LOSE:
  - loseShow 1 steady; mask 8'h7F.
  - Hold as in WIN using LOSE_HOLD_FRAMES, then -> TITLE.
- Counters:
  - The frame counter and blink counter reset to 0 on every state entry, and blink phase resets to 1.
  - Blink phase toggles when the blink count reaches BLINK_FRAMES-1; the count then wraps to 0.
  - Counter width is $clog2(max(WIN_HOLD_FRAMES, LOSE_HOLD_FRAMES, BLINK_FRAMES)+1).
- Returning to TITLE always clears winShow and loseShow.

Optional Feature:
- Macro SCREEN_PAUSE_EN.
- Defined: PAUSE state and pauseKey behave as above.
- Undefined: PAUSE state is not generated, the pauseKey latch is removed, pauseKey is ignored in PLAY, and stateOut never shows 3.

Decomposition:
- Package screen_pkg holds:
  - state enum: TITLE=0, PLAY=1, WIN=2, PAUSE=3, LOSE=4;
  - layer index constants, L_SCORE..L_WIN;
  - mask constants: MASK_TITLE 8'h0F, MASK_PLAY 8'h3F, MASK_LOSE 8'h7F.
- One sub-module, frame_tick_counter: frame-gated counter with synchronous clear, terminal-count flag and blink toggle. It is instantiated twice, once for hold and once for blink.

Test Plan:
- Reset, then startKey pulse mid-frame -> no change until next startOfFrame; then stateOut=1, layerEnable=8'h3F, gameActive=1, restartPulse high for exactly one cycle.
- In PLAY, assert playerWon and playerDied in the same frame -> WIN, not LOSE. With BLINK_FRAMES=2 and WIN_HOLD_FRAMES=6: winShow pattern 1,1,0,0,1,1 over frames, then TITLE with winShow=0 and mask 8'h0F.
- In PLAY, playerDied pulse coincident with startOfFrame -> LOSE on that edge; loseShow=1 and mask 8'h7F for LOSE_HOLD_FRAMES frames; startKey during hold is ignored.
- SCREEN_PAUSE_EN defined: pauseKey in PLAY -> PAUSE with gameActive=0 and kong bit blinking; playerDied during PAUSE is discarded; pauseKey -> PLAY. Undefined: pauseKey leaves state at 1.
- resetN low for 1 cycle mid-WIN (frame 3 of 6) -> immediate TITLE, mask 8'h0F, counters 0; the following startKey restarts normally.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and constants for the screen sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state encoding, layer bit indices, per-screen layer masks and a
// small helper for sizing the frame counters.
package screen_pkg;

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        PLAY  = 3'd1,
        WIN   = 3'd2,
        PAUSE = 3'd3,
        LOSE  = 3'd4
    } state_e;

    // Bit positions inside the layer enable mask.
    localparam int L_SCORE    = 0;
    localparam int L_LAVA     = 1;
    localparam int L_PLATFORM = 2;
    localparam int L_ROPE     = 3;
    localparam int L_TARGET   = 4;
    localparam int L_KONG     = 5;
    localparam int L_LOSE     = 6;
    localparam int L_WIN      = 7;

    localparam logic [7:0] MASK_TITLE = 8'h0F;
    localparam logic [7:0] MASK_PLAY  = 8'h3F;
    localparam logic [7:0] MASK_LOSE  = 8'h7F;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/screen_state_ctrl_frame_tick_counter.sv
// Frame-gated counter with synchronous clear, terminal-count flag and a blink phase toggle.
// Latency: count and phase update on the clock edge of a tick; tc_o and phase_d_o are combinational.
// Backpressure: none; every tick is consumed.
// Ports: clk, resetN (async active-low), tick_i (advance), clear_i (restart at 0, phase 1),
//        term_i (last count value before wrap), tc_o (count == term_i),
//        phase_d_o (phase value that will be registered on this edge).
module frame_tick_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o,
    output logic             phase_d_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             phase_q, phase_d;

    assign tc_o = (count_q == term_i);

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (clear_i) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (tick_i) begin
            if (tc_o) begin
                count_d = '0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Exposing the next phase lets the parent register outputs that change
    // on the same edge as the phase itself.
    assign phase_d_o = phase_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/screen_state_ctrl.sv
// Game screen sequencer (title/play/pause/win/lose) driving the VGA layer mask and overlays.
// Latency: state and all outputs registered; changes land on the startOfFrame edge.
// Backpressure: none; events are latched until the next frame boundary and then dropped.
// Ports: clk, resetN (async active-low), startOfFrame, startKey, pauseKey, playerWon,
//        playerDied in; layerEnable, winShow, loseShow, gameActive, restartPulse, stateOut out.
// Build option: define SCREEN_PAUSE_EN to include the PAUSE screen and the pauseKey path.
module screen_state_ctrl
    import screen_pkg::*;
#(
    parameter int NUM_LAYERS       = 8,
    parameter int BLINK_FRAMES     = 30,
    parameter int WIN_HOLD_FRAMES  = 180,
    parameter int LOSE_HOLD_FRAMES = 180
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  startKey,
    input  logic                  pauseKey,
    input  logic                  playerWon,
    input  logic                  playerDied,
    output logic [NUM_LAYERS-1:0] layerEnable,
    output logic                  winShow,
    output logic                  loseShow,
    output logic                  gameActive,
    output logic                  restartPulse,
    output logic [2:0]            stateOut
);

    localparam int CW = $clog2(max3(WIN_HOLD_FRAMES, LOSE_HOLD_FRAMES, BLINK_FRAMES) + 1);

    state_e state_q, state_d;

    logic start_lat_q, won_lat_q, died_lat_q;
    logic start_ev, won_ev, died_ev;

    logic [NUM_LAYERS-1:0] layer_q, layer_d;
    logic win_q, win_d, lose_q, lose_d, active_q, active_d, restart_q;

    logic          enter;
    logic [CW-1:0] hold_term;
    logic          hold_tc;
    logic          blink_phase_d;
    logic          unused_hold_phase;

    // An event on the frame-boundary cycle itself still counts for that frame.
    assign start_ev = startKey   | start_lat_q;
    assign won_ev   = playerWon  | won_lat_q;
    assign died_ev  = playerDied | died_lat_q;

`ifdef SCREEN_PAUSE_EN
    logic pause_lat_q;
    logic pause_ev;
    assign pause_ev = pauseKey | pause_lat_q;
`else
    logic unused_pause;
    assign unused_pause = pauseKey;
`endif

    always_comb begin
        state_d = state_q;
        if (startOfFrame) begin
            case (state_q)
                TITLE: if (start_ev) state_d = PLAY;
                PLAY: begin
                    if (won_ev)       state_d = WIN;
                    else if (died_ev) state_d = LOSE;
`ifdef SCREEN_PAUSE_EN
                    else if (pause_ev) state_d = PAUSE;
`endif
                end
`ifdef SCREEN_PAUSE_EN
                PAUSE: if (pause_ev) state_d = PLAY;
`endif
                WIN:   if (hold_tc) state_d = TITLE;
                LOSE:  if (hold_tc) state_d = TITLE;
                default: state_d = TITLE;
            endcase
        end
    end

    // Any state change clears both counters so every screen starts from frame 0.
    assign enter     = startOfFrame && (state_d != state_q);
    assign hold_term = (state_q == LOSE) ? CW'(LOSE_HOLD_FRAMES - 1) : CW'(WIN_HOLD_FRAMES - 1);

    frame_tick_counter #(.WIDTH(CW)) u_hold_cnt (
        .clk       (clk),
        .resetN    (resetN),
        .tick_i    (startOfFrame),
        .clear_i   (enter),
        .term_i    (hold_term),
        .tc_o      (hold_tc),
        .phase_d_o (unused_hold_phase)
    );

    frame_tick_counter #(.WIDTH(CW)) u_blink_cnt (
        .clk       (clk),
        .resetN    (resetN),
        .tick_i    (startOfFrame),
        .clear_i   (enter),
        .term_i    (CW'(BLINK_FRAMES - 1)),
        .tc_o      (),
        .phase_d_o (blink_phase_d)
    );

    // Outputs are derived from the next state/phase so they register together with them.
    always_comb begin
        layer_d  = NUM_LAYERS'(MASK_TITLE);
        win_d    = 1'b0;
        lose_d   = 1'b0;
        active_d = 1'b0;
        case (state_d)
            PLAY: begin
                layer_d  = NUM_LAYERS'(MASK_PLAY);
                active_d = 1'b1;
            end
`ifdef SCREEN_PAUSE_EN
            PAUSE: begin
                layer_d         = NUM_LAYERS'(MASK_PLAY);
                layer_d[L_KONG] = blink_phase_d;
            end
`endif
            WIN: begin
                layer_d        = NUM_LAYERS'(MASK_PLAY);
                layer_d[L_WIN] = blink_phase_d;
                win_d          = blink_phase_d;
            end
            LOSE: begin
                layer_d = NUM_LAYERS'(MASK_LOSE);
                lose_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= TITLE;
            start_lat_q <= 1'b0;
            won_lat_q   <= 1'b0;
            died_lat_q  <= 1'b0;
`ifdef SCREEN_PAUSE_EN
            pause_lat_q <= 1'b0;
`endif
            layer_q     <= NUM_LAYERS'(MASK_TITLE);
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            active_q    <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            active_q  <= active_d;
            restart_q <= startOfFrame && (state_q == TITLE) && (state_d == PLAY);
            // Latches live for one frame only: cleared on every boundary.
            if (startOfFrame) begin
                start_lat_q <= 1'b0;
                won_lat_q   <= 1'b0;
                died_lat_q  <= 1'b0;
`ifdef SCREEN_PAUSE_EN
                pause_lat_q <= 1'b0;
`endif
            end else begin
                start_lat_q <= start_lat_q | startKey;
                won_lat_q   <= won_lat_q   | playerWon;
                died_lat_q  <= died_lat_q  | playerDied;
`ifdef SCREEN_PAUSE_EN
                pause_lat_q <= pause_lat_q | pauseKey;
`endif
            end
        end
    end

    assign layerEnable  = layer_q;
    assign winShow      = win_q;
    assign loseShow     = lose_q;
    assign gameActive   = active_q;
    assign restartPulse = restart_q;
    assign stateOut     = state_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Self-checking bench for screen_state_ctrl with short hold/blink periods.
// Reference model tracks screen and frames-since-entry; blink derived arithmetically.
// Directed literal checks pin reset, transitions, blink pattern, hold lengths and reset mid-hold.
module tb_screen_state_ctrl;

    localparam int NL  = 8;
    localparam int BF  = 2;
    localparam int WHF = 6;
    localparam int LHF = 4;
`ifdef SCREEN_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          startOfFrame = 1'b0;
    logic          startKey = 1'b0;
    logic          pauseKey = 1'b0;
    logic          playerWon = 1'b0;
    logic          playerDied = 1'b0;
    logic [NL-1:0] layerEnable;
    logic          winShow, loseShow, gameActive, restartPulse;
    logic [2:0]    stateOut;

    int checks = 0;
    int failures = 0;

    screen_state_ctrl #(
        .NUM_LAYERS(NL), .BLINK_FRAMES(BF),
        .WIN_HOLD_FRAMES(WHF), .LOSE_HOLD_FRAMES(LHF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .startKey(startKey), .pauseKey(pauseKey), .playerWon(playerWon),
        .playerDied(playerDied), .layerEnable(layerEnable), .winShow(winShow),
        .loseShow(loseShow), .gameActive(gameActive), .restartPulse(restartPulse),
        .stateOut(stateOut)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // screen codes: 0 title, 1 play, 2 win, 3 pause, 4 lose
    int m_st = 0;
    int m_fr = 0;
    bit m_rs = 1'b0;
    bit l_st = 1'b0, l_pa = 1'b0, l_wo = 1'b0, l_di = 1'b0;
    bit e_st, e_pa, e_wo, e_di;
    int m_nx;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_st = 0; m_fr = 0; m_rs = 1'b0;
            l_st = 1'b0; l_pa = 1'b0; l_wo = 1'b0; l_di = 1'b0;
        end else begin
            e_st = startKey | l_st;
            e_pa = PAUSE_ON & (pauseKey | l_pa);
            e_wo = playerWon | l_wo;
            e_di = playerDied | l_di;
            m_rs = 1'b0;
            if (startOfFrame) begin
                m_nx = m_st;
                case (m_st)
                    0: if (e_st) begin m_nx = 1; m_rs = 1'b1; end
                    1: if (e_wo) m_nx = 2; else if (e_di) m_nx = 4; else if (e_pa) m_nx = 3;
                    3: if (e_pa) m_nx = 1;
                    2: if (m_fr == WHF - 1) m_nx = 0;
                    4: if (m_fr == LHF - 1) m_nx = 0;
                    default: m_nx = 0;
                endcase
                if (m_nx != m_st) begin m_st = m_nx; m_fr = 0; end
                else m_fr = m_fr + 1;
                l_st = 1'b0; l_pa = 1'b0; l_wo = 1'b0; l_di = 1'b0;
            end else begin
                l_st = l_st | startKey;
                l_pa = l_pa | pauseKey;
                l_wo = l_wo | playerWon;
                l_di = l_di | playerDied;
            end
        end
    end

    function automatic logic [14:0] model_vec();
        bit       ph;
        logic [7:0] mk;
        ph = ((m_fr / BF) % 2) == 0;
        case (m_st)
            1: mk = 8'h3F;
            2: mk = ph ? 8'hBF : 8'h3F;
            3: mk = ph ? 8'h3F : 8'h1F;
            4: mk = 8'h7F;
            default: mk = 8'h0F;
        endcase
        return {3'(m_st), mk, (m_st == 2) && ph, m_st == 4, m_st == 1, m_rs};
    endfunction

    // ---------------- helpers ----------------
    task automatic model_cmp();
        logic [14:0] act, exp;
        act = {stateOut, layerEnable, winShow, loseShow, gameActive, restartPulse};
        exp = model_vec();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic sof_frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    // e = {start, pause, won, died}, held for one cycle
    task automatic ev(input logic [3:0] e);
        {startKey, pauseKey, playerWon, playerDied} = e;
        step();
        {startKey, pauseKey, playerWon, playerDied} = 4'b0000;
    endtask

    int exp_ws [6] = '{1, 1, 0, 0, 1, 1};

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        check("rst_state", stateOut, 0);
        check("rst_mask", layerEnable, 8'h0F);
        check("rst_win", winShow, 0);
        check("rst_active", gameActive, 0);
        check("rst_restart", restartPulse, 0);

        sof_frame(); idle(3);
        ev(4'b1000); idle(2);
        check("start_wait_state", stateOut, 0);
        sof_frame();
        check("play_state", stateOut, 1);
        check("play_mask", layerEnable, 8'h3F);
        check("play_active", gameActive, 1);
        check("restart_hi", restartPulse, 1);
        step();
        check("restart_lo", restartPulse, 0);
        idle(2);

        // won and died in one frame: won wins
        ev(4'b0011); idle(1);
        for (int k = 0; k < WHF; k++) begin
            sof_frame();
            check("win_state", stateOut, 2);
            check("win_blink", winShow, exp_ws[k]);
            idle(3);
        end
        sof_frame();
        check("win_exit_state", stateOut, 0);
        check("win_exit_show", winShow, 0);
        check("win_exit_mask", layerEnable, 8'h0F);
        idle(3);

        // died coincident with frame boundary
        ev(4'b1000); sof_frame(); idle(3);
        check("play2_state", stateOut, 1);
        playerDied = 1'b1; startOfFrame = 1'b1;
        step();
        playerDied = 1'b0; startOfFrame = 1'b0;
        check("lose_state", stateOut, 4);
        check("lose_show", loseShow, 1);
        check("lose_mask", layerEnable, 8'h7F);
        idle(1); ev(4'b1000); idle(1);
        for (int k = 1; k < LHF; k++) begin
            sof_frame();
            check("lose_hold", stateOut, 4);
            idle(3);
        end
        sof_frame();
        check("lose_exit_state", stateOut, 0);
        check("lose_exit_show", loseShow, 0);
        idle(3);

        // pause path
        ev(4'b1000); sof_frame(); idle(3);
        ev(4'b0100); idle(1); sof_frame();
`ifdef SCREEN_PAUSE_EN
        check("pause_state", stateOut, 3);
        check("pause_active", gameActive, 0);
        check("pause_kong_on", layerEnable[5], 1);
        idle(3);
        ev(4'b0001); sof_frame();
        check("pause_died_discard", stateOut, 3);
        idle(3); sof_frame();
        check("pause_kong_off", layerEnable[5], 0);
        idle(3);
        ev(4'b0100); sof_frame();
        check("unpause_state", stateOut, 1);
`else
        check("nopause_state", stateOut, 1);
        check("nopause_active", gameActive, 1);
`endif
        idle(3);

        // reset in the middle of a win hold
        ev(4'b0010); sof_frame();
        check("win2_state", stateOut, 2);
        idle(3); sof_frame(); idle(3); sof_frame();
        idle(1);
        resetN = 1'b0;
        #1;
        check("midrst_state", stateOut, 0);
        check("midrst_mask", layerEnable, 8'h0F);
        check("midrst_win", winShow, 0);
        step();
        resetN = 1'b1;
        idle(2);
        ev(4'b1000); sof_frame();
        check("restart2_state", stateOut, 1);
        check("restart2_pulse", restartPulse, 1);
        idle(2);
        ev(4'b0010); sof_frame();
        check("win3_blink0", winShow, 1);
        idle(3); sof_frame();
        check("win3_blink1", winShow, 1);
        idle(3); sof_frame();
        check("win3_blink2", winShow, 0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
